// File: rtl/axi_time_counter_mc_if.sv
// Bus bundle for the timestamp counter: run control, overwrite handshake,
// capture channels and compare alarm.
interface axi_time_counter_mc_if #(
  parameter int COUNT_WIDTH = 64,
  parameter int INC_WIDTH   = 8,
  parameter int NUM_CAPTURE = 4
);
  logic                               sync_in;
  logic                               time_enable;
  logic                               time_sync_ext;
  logic                               time_sync_soft;
  logic [INC_WIDTH-1:0]               time_increment;
  logic                               time_overwrite_valid;
  logic                               time_overwrite_ready;
  logic [COUNT_WIDTH-1:0]             time_overwrite;
  logic [COUNT_WIDTH-1:0]             time_counter;
  logic [NUM_CAPTURE-1:0]             capture_in;
  logic [NUM_CAPTURE-1:0]             capture_valid;
  logic [NUM_CAPTURE-1:0]             capture_ready;
  logic [NUM_CAPTURE*COUNT_WIDTH-1:0] capture_data;
  logic [NUM_CAPTURE-1:0]             capture_overflow;
  logic                               compare_enable;
  logic [COUNT_WIDTH-1:0]             compare_value;
  logic                               compare_match;

  modport slave (
    input  sync_in, time_enable, time_sync_ext, time_sync_soft, time_increment,
           time_overwrite_valid, time_overwrite, capture_in, capture_ready,
           compare_enable, compare_value,
    output time_overwrite_ready, time_counter, capture_valid, capture_data,
           capture_overflow, compare_match
  );

  modport master (
    output sync_in, time_enable, time_sync_ext, time_sync_soft, time_increment,
           time_overwrite_valid, time_overwrite, capture_in, capture_ready,
           compare_enable, compare_value,
    input  time_overwrite_ready, time_counter, capture_valid, capture_data,
           capture_overflow, compare_match
  );
endinterface

// File: rtl/axi_time_counter_mc.sv
// Free-running timestamp counter with sync/overwrite reload, per-channel
// event capture (valid/ready with overflow flag) and a compare alarm.

// One capture channel: holds a timestamp until consumed, flags lost events.
module axi_time_counter_mc_cap #(
  parameter int COUNT_WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   ev_i,
  input  logic                   ready_i,
  input  logic [COUNT_WIDTH-1:0] counter_i,
  output logic                   valid_o,
  output logic                   overflow_o,
  output logic [COUNT_WIDTH-1:0] data_o
);
  logic                   valid_q, valid_d;
  logic                   ovf_q, ovf_d;
  logic [COUNT_WIDTH-1:0] data_q, data_d;
  logic                   xfer;

  // Next state: a new event either refills the slot (free or being drained
  // this cycle) or is dropped and flagged; an accepted transfer empties it.
  always_comb begin
    valid_d = valid_q;
    ovf_d   = ovf_q;
    data_d  = data_q;
    xfer    = valid_q & ready_i;
    if (ev_i) begin
      if (!valid_q || ready_i) begin
        data_d  = counter_i;
        valid_d = 1'b1;
        ovf_d   = 1'b0;
      end else begin
        ovf_d   = 1'b1;
      end
    end else if (xfer) begin
      valid_d = 1'b0;
      ovf_d   = 1'b0;
    end
  end

  // Channel state registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      data_q  <= data_d;
    end
  end

  assign valid_o    = valid_q;
  assign overflow_o = ovf_q;
  assign data_o     = data_q;
endmodule

module axi_time_counter_mc #(
  parameter int COUNT_WIDTH       = 64,
  parameter int INC_WIDTH         = 8,
  parameter int NUM_CAPTURE       = 4,
  parameter int SYNC_EXTERNAL_CDC = 1
) (
  input logic clk,
  input logic resetn,
  axi_time_counter_mc_if.slave bus
);
  logic                                    sync_ev;
  logic [NUM_CAPTURE-1:0]                  cap_ev;
  logic                                    time_reset;
  logic                                    arm;
  logic [COUNT_WIDTH-1:0]                  inc_ext;
  logic [COUNT_WIDTH-1:0]                  cnt_sum;
  logic [COUNT_WIDTH-1:0]                  cnt_q, cnt_d;
  logic                                    armed_q, armed_d;
  logic [COUNT_WIDTH-1:0]                  ovr_q, ovr_d;
  logic                                    match_q, match_d;
  logic [NUM_CAPTURE-1:0]                  cap_valid;
  logic [NUM_CAPTURE-1:0]                  cap_ovf;
  logic [NUM_CAPTURE-1:0][COUNT_WIDTH-1:0] cap_data;

  if (SYNC_EXTERNAL_CDC != 0) begin : g_cdc
    logic [2:0]             sync_pipe_q;
    logic [NUM_CAPTURE-1:0] cap_s1_q, cap_s2_q, cap_s3_q;

    // Two synchroniser flops plus an edge flop; events are rising edges.
    always_ff @(posedge clk) begin
      if (!resetn) begin
        sync_pipe_q <= '0;
        cap_s1_q    <= '0;
        cap_s2_q    <= '0;
        cap_s3_q    <= '0;
      end else begin
        sync_pipe_q <= {sync_pipe_q[1:0], bus.sync_in};
        cap_s1_q    <= bus.capture_in;
        cap_s2_q    <= cap_s1_q;
        cap_s3_q    <= cap_s2_q;
      end
    end

    assign sync_ev = sync_pipe_q[1] & ~sync_pipe_q[2];
    assign cap_ev  = cap_s2_q & ~cap_s3_q;
  end else begin : g_nocdc
    // Inputs already in clk domain: the level itself is the event.
    assign sync_ev = bus.sync_in;
    assign cap_ev  = bus.capture_in;
  end

  // Counter, overwrite slot and compare alarm next-state.
  always_comb begin
    time_reset = (sync_ev & bus.time_sync_ext) | bus.time_sync_soft;
    arm        = bus.time_enable & bus.time_overwrite_valid;
    inc_ext    = COUNT_WIDTH'(bus.time_increment);
    cnt_sum    = cnt_q + inc_ext;

    cnt_d = cnt_q;
    if (time_reset)           cnt_d = armed_q ? ovr_q : '0;
    else if (bus.time_enable) cnt_d = cnt_sum;

    // Arm beats clear; a fresh value is taken only when the slot is free
    // or is being consumed by this same sync.
    armed_d = armed_q;
    ovr_d   = ovr_q;
    if (arm) begin
      armed_d = 1'b1;
      if (!armed_q || time_reset) ovr_d = bus.time_overwrite;
    end else if (time_reset) begin
      armed_d = 1'b0;
    end

    // Alarm when the threshold lies in the half-open step (old, new],
    // with the interval wrapping through zero when the sum overflows.
    match_d = 1'b0;
    if (!time_reset && bus.time_enable && bus.compare_enable &&
        (bus.time_increment != '0)) begin
      if (cnt_sum > cnt_q)
        match_d = (bus.compare_value > cnt_q) && (bus.compare_value <= cnt_sum);
      else
        match_d = (bus.compare_value > cnt_q) || (bus.compare_value <= cnt_sum);
    end
  end

  // Counter, overwrite slot and alarm registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_q   <= '0;
      armed_q <= 1'b0;
      ovr_q   <= '0;
      match_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
      ovr_q   <= ovr_d;
      match_q <= match_d;
    end
  end

  for (genvar i = 0; i < NUM_CAPTURE; i++) begin : g_cap
    axi_time_counter_mc_cap #(.COUNT_WIDTH(COUNT_WIDTH)) u_cap (
      .clk        (clk),
      .resetn     (resetn),
      .ev_i       (cap_ev[i]),
      .ready_i    (bus.capture_ready[i]),
      .counter_i  (cnt_q),
      .valid_o    (cap_valid[i]),
      .overflow_o (cap_ovf[i]),
      .data_o     (cap_data[i])
    );
  end

  assign bus.time_counter         = cnt_q;
  assign bus.time_overwrite_ready = ~armed_q;
  assign bus.compare_match        = match_q;
  assign bus.capture_valid        = cap_valid;
  assign bus.capture_overflow     = cap_ovf;
  assign bus.capture_data         = cap_data;
endmodule

// File: tb/tb_axi_time_counter_mc.sv
// Bench: 64-bit/CDC instance for directed and table checks, 8-bit/no-CDC
// instance for wrap/compare checks and a randomized run against a model.
module tb_axi_time_counter_mc;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  axi_time_counter_mc_if #(.COUNT_WIDTH(64), .INC_WIDTH(8), .NUM_CAPTURE(4)) b64 ();
  axi_time_counter_mc_if #(.COUNT_WIDTH(8),  .INC_WIDTH(8), .NUM_CAPTURE(2)) b8 ();

  axi_time_counter_mc #(.COUNT_WIDTH(64), .INC_WIDTH(8), .NUM_CAPTURE(4),
                        .SYNC_EXTERNAL_CDC(1)) u_dut64 (.clk(clk), .resetn(resetn), .bus(b64));
  axi_time_counter_mc #(.COUNT_WIDTH(8), .INC_WIDTH(8), .NUM_CAPTURE(2),
                        .SYNC_EXTERNAL_CDC(0)) u_dut8 (.clk(clk), .resetn(resetn), .bus(b8));

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    b64.sync_in = 0; b64.time_enable = 0; b64.time_sync_ext = 0; b64.time_sync_soft = 0;
    b64.time_increment = 0; b64.time_overwrite_valid = 0; b64.time_overwrite = 0;
    b64.capture_in = 0; b64.capture_ready = 0; b64.compare_enable = 0; b64.compare_value = 0;
    b8.sync_in = 0; b8.time_enable = 0; b8.time_sync_ext = 0; b8.time_sync_soft = 0;
    b8.time_increment = 0; b8.time_overwrite_valid = 0; b8.time_overwrite = 0;
    b8.capture_in = 0; b8.capture_ready = 0; b8.compare_enable = 0; b8.compare_value = 0;
  endtask

  typedef struct {
    logic        en;
    logic [7:0]  inc;
    int          cycles;
    logic [63:0] exp_cnt;
  } vec_t;

  vec_t vt[5];

  // behavioural model of the 8-bit instance
  logic [7:0] m_cnt, m_ovr;
  logic       m_armed, m_match;
  logic [1:0] m_val, m_ovf;
  logic [7:0] m_dat[2];

  initial begin
    logic [63:0] c;
    vt[0] = '{1'b1, 8'd3,   10, 64'd30};
    vt[1] = '{1'b0, 8'd5,   4,  64'd30};
    vt[2] = '{1'b1, 8'd0,   3,  64'd30};
    vt[3] = '{1'b1, 8'd255, 2,  64'd540};
    vt[4] = '{1'b1, 8'd1,   1,  64'd541};

    idle_all();
    resetn = 0;
    step(3);
    chk("rst_counter",  b64.time_counter, 64'd0);
    chk("rst_ready",    64'(b64.time_overwrite_ready), 64'd1);
    chk("rst_valid",    64'(b64.capture_valid), 64'd0);
    chk("rst_ovf",      64'(b64.capture_overflow), 64'd0);
    chk("rst_data",     64'(b64.capture_data[63:0]), 64'd0);
    chk("rst_match",    64'(b64.compare_match), 64'd0);
    resetn = 1;

    // table: run-enable / increment sequences from reset
    for (int i = 0; i < 5; i++) begin
      b64.time_enable = vt[i].en;
      b64.time_increment = vt[i].inc;
      step(vt[i].cycles);
      chk($sformatf("vec%0d_counter", i), b64.time_counter, vt[i].exp_cnt);
    end

    // overwrite then soft sync
    b64.time_enable = 1; b64.time_increment = 0;
    b64.time_overwrite_valid = 1; b64.time_overwrite = 64'h1000;
    step(1);
    b64.time_overwrite_valid = 0; b64.time_overwrite = 0;
    chk("ow_ready_armed", 64'(b64.time_overwrite_ready), 64'd0);
    step(1);
    chk("ow_hold_counter", b64.time_counter, 64'd541);
    b64.time_sync_soft = 1;
    step(1);
    b64.time_sync_soft = 0;
    chk("ow_loaded", b64.time_counter, 64'h1000);
    chk("ow_ready_back", 64'(b64.time_overwrite_ready), 64'd1);

    // external sync through the CDC: reload exactly 3 edges after the rise
    b64.time_increment = 1; b64.time_sync_ext = 1; b64.sync_in = 1;
    step(2);
    chk("sync_not_early", b64.time_counter, 64'h1002);
    step(1);
    chk("sync_reload", b64.time_counter, 64'd0);
    step(1);
    chk("sync_edge_once", b64.time_counter, 64'd1);
    b64.sync_in = 0;
    step(3);
    b64.time_sync_ext = 0; b64.sync_in = 1;
    step(5);
    chk("sync_disarmed", b64.time_counter, 64'd9);
    b64.sync_in = 0;

    // capture channel 2: two events with ready low, then drain
    c = 64'd9;
    b64.capture_in = 4'b0100;
    step(3);
    chk("cap_valid", 64'(b64.capture_valid), 64'h4);
    chk("cap_data", b64.capture_data[2*64 +: 64], c + 2);
    b64.capture_in = 0;
    step(2);
    b64.capture_in = 4'b0100;
    step(3);
    chk("cap_ovf_set", 64'(b64.capture_overflow), 64'h4);
    chk("cap_data_held", b64.capture_data[2*64 +: 64], c + 2);
    b64.capture_in = 0;
    b64.capture_ready = 4'b0100;
    step(1);
    b64.capture_ready = 0;
    chk("cap_drained", 64'(b64.capture_valid), 64'd0);
    chk("cap_ovf_clr", 64'(b64.capture_overflow), 64'd0);

    // reset mid-handshake discards held capture and pending overwrite
    b64.time_overwrite_valid = 1; b64.time_overwrite = 64'hABC;
    b64.capture_in = 4'b0010;
    step(1);
    b64.time_overwrite_valid = 0;
    step(2);
    chk("mid_valid", 64'(b64.capture_valid), 64'h2);
    b64.capture_in = 0;
    resetn = 0;
    step(1);
    chk("mid_rst_ready", 64'(b64.time_overwrite_ready), 64'd1);
    chk("mid_rst_valid", 64'(b64.capture_valid), 64'd0);
    resetn = 1;
    b64.time_sync_soft = 1;
    step(1);
    b64.time_sync_soft = 0;
    chk("mid_no_stale_ow", b64.time_counter, 64'd0);
    idle_all();

    // 8-bit: wrap with compare hit
    b8.time_enable = 1; b8.time_overwrite_valid = 1; b8.time_overwrite = 8'hFE;
    step(1);
    b8.time_overwrite_valid = 0;
    b8.compare_enable = 1; b8.compare_value = 8'hFE; b8.time_sync_soft = 1;
    step(1);
    b8.time_sync_soft = 0;
    chk("w8_loaded", 64'(b8.time_counter), 64'hFE);
    chk("w8_no_match_load", 64'(b8.compare_match), 64'd0);
    b8.time_increment = 4; b8.compare_value = 8'h01;
    step(1);
    chk("w8_wrapped", 64'(b8.time_counter), 64'h02);
    chk("w8_match", 64'(b8.compare_match), 64'd1);
    b8.time_increment = 0; b8.compare_value = 8'h02;
    step(1);
    chk("w8_match_once", 64'(b8.compare_match), 64'd0);
    idle_all();

    // randomized run of the 8-bit instance against the model
    resetn = 0;
    step(2);
    resetn = 1;
    m_cnt = 0; m_ovr = 0; m_armed = 0; m_match = 0; m_val = 0; m_ovf = 0;
    m_dat[0] = 0; m_dat[1] = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      logic tr, arm;
      logic [7:0] inc;
      b8.time_enable          = ($urandom % 4) != 0;
      inc                     = (($urandom % 8) == 0) ? 8'($urandom) : 8'($urandom_range(0, 7));
      b8.time_increment       = inc;
      b8.sync_in              = ($urandom % 2) == 1;
      b8.time_sync_ext        = ($urandom % 2) == 1;
      b8.time_sync_soft       = ($urandom % 16) == 0;
      b8.time_overwrite_valid = ($urandom % 4) == 0;
      b8.time_overwrite       = 8'($urandom);
      b8.capture_in           = {(($urandom % 4) == 0), (($urandom % 4) == 0)};
      b8.capture_ready        = 2'($urandom);
      b8.compare_enable       = ($urandom % 2) == 1;
      b8.compare_value        = (($urandom % 2) == 1) ? 8'(m_cnt + 8'($urandom_range(0, 8)))
                                                      : 8'($urandom);

      tr  = (b8.sync_in && b8.time_sync_ext) || b8.time_sync_soft;
      arm = b8.time_enable && b8.time_overwrite_valid;
      // alarm: distance from old count to threshold, mod 256, within 1..step
      m_match = !tr && b8.time_enable && b8.compare_enable && (inc != 0) &&
                (8'(b8.compare_value - m_cnt) >= 8'd1) && (8'(b8.compare_value - m_cnt) <= inc);
      for (int ch = 0; ch < 2; ch++) begin
        if (b8.capture_in[ch]) begin
          if (!m_val[ch] || b8.capture_ready[ch]) begin
            m_dat[ch] = m_cnt; m_val[ch] = 1; m_ovf[ch] = 0;
          end else m_ovf[ch] = 1;
        end else if (m_val[ch] && b8.capture_ready[ch]) begin
          m_val[ch] = 0; m_ovf[ch] = 0;
        end
      end
      if (tr) m_cnt = m_armed ? m_ovr : 8'd0;
      else if (b8.time_enable) m_cnt = m_cnt + inc;
      if (arm) begin
        if (!m_armed || tr) m_ovr = b8.time_overwrite;
        m_armed = 1;
      end else if (tr) m_armed = 0;

      step(1);
      chk("rnd_counter", 64'(b8.time_counter), 64'(m_cnt));
      chk("rnd_ready",   64'(b8.time_overwrite_ready), 64'(!m_armed));
      chk("rnd_match",   64'(b8.compare_match), 64'(m_match));
      chk("rnd_valid",   64'(b8.capture_valid), 64'(m_val));
      chk("rnd_ovf",     64'(b8.capture_overflow), 64'(m_ovf));
      for (int ch = 0; ch < 2; ch++)
        if (m_val[ch])
          chk($sformatf("rnd_data%0d", ch), 64'(b8.capture_data[ch*8 +: 8]), 64'(m_dat[ch]));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
